seg_pipe_adder: RTL



---
 rtl/seg_pipe_adder_pkg.sv | 31 +++
 rtl/seg_add_stage.sv | 44 ++++
 rtl/seg_pipe_adder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg_pipe_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pipe_adder_pkg                                                       |
// | Shared helpers and types for the segmented pipelined adder:              |
// |   calc_nstg   - number of pipeline stages (one per SEG-bit segment)      |
// |   seg_cfg_ok  - legality of a WIDTH/SEG pair, used at elaboration time   |
// |   stage_ctl_t - per-stage control record (valid flag, inter-stage carry) |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package seg_pipe_adder_pkg;

  // Stages needed to cover WIDTH bits with SEG-bit segments.
  function automatic int calc_nstg(input int width, input int seg);
    return (seg > 0) ? (width / seg) : 1;
  endfunction

  // WIDTH must be a positive whole multiple of SEG.
  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  // Control half of a stage record. The data half (partial sum and the
  // skewed operand slices still waiting for their carry) narrows or widens
  // from stage to stage, so it is declared per stage next to this record.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/seg_add_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_add_stage                                                            |
// | Combinational SEG-bit ripple adder built from XOR/MUX full-adder cells.  |
// | Ports:                                                                   |
// |   a_seg, b_seg [SEG] in  : operand segments                              |
// |   ci               in  : carry into bit 0                                |
// |   s_seg [SEG]      out : segment sum                                     |
// |   co               out : carry out of the segment MSB                    |
// |   c_msb_in         out : carry into the segment MSB (overflow detection) |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg_add_stage
  import seg_pipe_adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           ci,
  output logic [SEG-1:0] s_seg,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  // Each cell: propagate = a^b; sum = propagate^cin;
  // carry-out selects cin when propagating, otherwise a (generate/kill).
  always_comb begin
    c     = '0;
    s_seg = '0;
    c[0]  = ci;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] ^ b_seg[i]) ? c[i] : a_seg[i];
    end
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule
`default_nettype wire

// File: rtl/seg_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pipe_adder                                                           |
// | WIDTH-bit add/subtract split into SEG-bit segments, one per pipeline     |
// | stage, with the carry registered between stages. Latency NSTG cycles,   |
// | one beat per cycle, valid/ready handshake with full-pipeline stall.      |
// | Ports:                                                                   |
// |   clk, rst (async, active-high)                                          |
// |   in_valid / in_ready       : operand handshake                          |
// |   a, b [WIDTH], cin, sub    : sub=0 -> a+b+cin, sub=1 -> a-b             |
// |   out_valid / out_ready     : result handshake                           |
// |   sum [WIDTH], cout, ovf    : result, carry (1 = no borrow), overflow    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = calc_nstg(WIDTH, SEG);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("seg_pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipeline freezes while a result waits at the output; no bubble
  // collapsing, so one enable serves every register.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Subtract is a + ~b + 1; the caller's cin is ignored then.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG - 1;

    // Operand bits from this segment upward, as seen by this stage.
    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    logic              ci;
    logic              v_in;
    logic [HI:0]       sum_d;
    logic [SEG-1:0]    s_seg;
    logic              co;
    logic              c_msb;
    stage_ctl_t        ctl_q;
    logic [HI:0]       sum_q;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign ci    = cin_eff;
      assign v_in  = in_valid;
      assign sum_d = s_seg;
    end else begin : g_body
      assign a_src = g_stage[k-1].g_skew.opa_q;
      assign b_src = g_stage[k-1].g_skew.opb_q;
      assign ci    = g_stage[k-1].ctl_q.carry;
      assign v_in  = g_stage[k-1].ctl_q.valid;
      // Lower segments ride along so all segments emerge together.
      assign sum_d = {s_seg, g_stage[k-1].sum_q};
    end

    seg_add_stage #(
      .SEG (SEG)
    ) u_add (
      .a_seg    (a_src[HI:LO]),
      .b_seg    (b_src[HI:LO]),
      .ci       (ci),
      .s_seg    (s_seg),
      .co       (co),
      .c_msb_in (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q.valid <= v_in;
        ctl_q.carry <= co;
        sum_q       <= sum_d;
      end
    end

    if (k < NSTG - 1) begin : g_skew
      // Upper operand segments wait here until their carry arrives.
      logic [WIDTH-1:HI+1] opa_q;
      logic [WIDTH-1:HI+1] opb_q;
      logic                unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv) begin
          opa_q <= a_src[WIDTH-1:HI+1];
          opb_q <= b_src[WIDTH-1:HI+1];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb ^ co;
        end
      end

      assign out_valid = ctl_q.valid;
      assign sum       = sum_q;
      assign cout      = ctl_q.carry;
      assign ovf       = ovf_q;
    end
  end

endmodule
`default_nettype wire
